// File: rtl/spi_cmd_slave_sync.sv
// SPI command slave, oversampled in the clk domain: receives {rq, address, turnaround, command}
// frames MSB first and returns status bits plus an optional handshaked reply word.
module spi_cmd_slave_sync #(
  parameter int unsigned ADR_WIDTH   = 3,
  parameter int unsigned CMD_WIDTH   = 8,
  parameter int unsigned REPLY_WIDTH = 8,
  parameter int unsigned STAT_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   sel,
  input  logic                   sdi,
  output logic                   sdo,
  input  logic [STAT_WIDTH-1:0]  status_in,
  output logic                   reply_req,
  output logic [ADR_WIDTH-1:0]   reply_adr,
  input  logic [REPLY_WIDTH-1:0] reply_data,
  output logic                   cmd_valid,
  output logic [ADR_WIDTH-1:0]   cmd_adr,
  output logic [CMD_WIDTH-1:0]   cmd_data,
  output logic                   cmd_reply,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned H     = 1 + ADR_WIDTH;
  localparam int unsigned FRAME = H + 1 + CMD_WIDTH;
  localparam int unsigned CW    = $clog2(FRAME + 2);

  typedef enum logic [2:0] {IDLE, WAIT, HEADER, TURN, CMD, DONE} state_t;

  state_t                 state;
  logic [1:0]             sck_sync, sel_sync, sdi_sync;
  logic                   sck_prev;
  logic                   fall, sel_act, sdi_b;
  logic [CW-1:0]          cnt, cnt_inc;
  int unsigned            n;
  logic                   rq;
  logic [ADR_WIDTH-1:0]   adr_sh, adr_next;
  logic [CMD_WIDTH-1:0]   cmd_sh, cmd_next;
  logic [STAT_WIDTH-1:0]  stat_sh, stat_next;
  logic [REPLY_WIDTH-1:0] rep_sh, rep_next;

  // Synchronizers run through reset so the sel level is known when rst releases.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[0], sck};
    sel_sync <= {sel_sync[0], sel};
    sdi_sync <= {sdi_sync[0], sdi};
    sck_prev <= sck_sync[1];
  end

  always_comb begin
    fall      = sck_prev & ~sck_sync[1];
    sel_act   = ~sel_sync[1];
    sdi_b     = sdi_sync[1];
    cnt_inc   = (cnt == CW'(FRAME + 1)) ? cnt : cnt + CW'(1);
    n         = 32'(cnt_inc);
    adr_next  = ADR_WIDTH'({adr_sh, sdi_b});
    cmd_next  = CMD_WIDTH'({cmd_sh, sdi_b});
    stat_next = stat_sh << 1;
    rep_next  = rep_sh << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= sel_act ? WAIT : IDLE;
      cnt       <= '0;
      rq        <= 1'b0;
      adr_sh    <= '0;
      cmd_sh    <= '0;
      stat_sh   <= '0;
      rep_sh    <= '0;
      sdo       <= 1'b0;
      reply_req <= 1'b0;
      reply_adr <= '0;
      cmd_valid <= 1'b0;
      cmd_adr   <= '0;
      cmd_data  <= '0;
      cmd_reply <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= sel_act;
      reply_req <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_adr   <= '0;
      cmd_data  <= '0;
      cmd_reply <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (sel_act) begin
            state   <= HEADER;
            cnt     <= '0;
            rq      <= 1'b0;
            adr_sh  <= '0;
            cmd_sh  <= '0;
            stat_sh <= status_in;
            sdo     <= status_in[STAT_WIDTH-1];
          end
        end
        WAIT: begin
          sdo <= 1'b0;
          if (!sel_act) state <= IDLE;
        end
        default: begin
          if (!sel_act) begin
            state <= IDLE;
            sdo   <= 1'b0;
            // Only an exact FRAME count (DONE, not saturated) or no edges at all ends cleanly.
            if (cnt != '0 && cnt != CW'(FRAME)) frame_err <= 1'b1;
          end else if (fall) begin
            cnt <= cnt_inc;
            sdo <= 1'b0;
            if (n < H) begin
              stat_sh <= stat_next;
              sdo     <= stat_next[STAT_WIDTH-1];
            end
            if (n == 1) rq <= sdi_b;
            if (n >= 2 && n <= H) adr_sh <= adr_next;
            if (n == H) begin
              state     <= TURN;
              reply_req <= 1'b1;
              reply_adr <= adr_next;
            end
            if (n == H + 1) begin
              state  <= CMD;
              rep_sh <= reply_data;
              sdo    <= rq & reply_data[REPLY_WIDTH-1];
            end
            if (n >= H + 2 && n <= H + REPLY_WIDTH) begin
              rep_sh <= rep_next;
              sdo    <= rq & rep_next[REPLY_WIDTH-1];
            end
            if (n >= H + 2 && n <= FRAME) cmd_sh <= cmd_next;
            if (n == FRAME) begin
              state     <= DONE;
              cmd_valid <= 1'b1;
              cmd_adr   <= adr_sh;
              cmd_data  <= cmd_next;
              cmd_reply <= rq;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave_sync.sv
// Directed bench: default instance (a) and a wide instance (b) share sck/sdi, separate sel lines.
module tb_spi_cmd_slave_sync;
  localparam int unsigned HALF = 60;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, sdi = 1'b0, sel_a = 1'b1, sel_b = 1'b1;
  logic [1:0]  status_a = 2'b10;
  logic [4:0]  status_b = 5'b10110;
  logic [7:0]  rdata_a, resp_a = 8'h3C;
  logic [11:0] rdata_b, resp_b = 12'hABC;

  logic        sdo_a, reply_req_a, cmd_valid_a, cmd_reply_a, frame_err_a, busy_a;
  logic [2:0]  reply_adr_a, cmd_adr_a;
  logic [7:0]  cmd_data_a;
  logic        sdo_b, reply_req_b, cmd_valid_b, cmd_reply_b, frame_err_b, busy_b;
  logic [3:0]  reply_adr_b, cmd_adr_b;
  logic [15:0] cmd_data_b;

  spi_cmd_slave_sync u_a (
    .clk(clk), .rst(rst), .sck(sck), .sel(sel_a), .sdi(sdi), .sdo(sdo_a),
    .status_in(status_a), .reply_req(reply_req_a), .reply_adr(reply_adr_a),
    .reply_data(rdata_a), .cmd_valid(cmd_valid_a), .cmd_adr(cmd_adr_a),
    .cmd_data(cmd_data_a), .cmd_reply(cmd_reply_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  spi_cmd_slave_sync #(.ADR_WIDTH(4), .CMD_WIDTH(16), .REPLY_WIDTH(12), .STAT_WIDTH(5)) u_b (
    .clk(clk), .rst(rst), .sck(sck), .sel(sel_b), .sdi(sdi), .sdo(sdo_b),
    .status_in(status_b), .reply_req(reply_req_b), .reply_adr(reply_adr_b),
    .reply_data(rdata_b), .cmd_valid(cmd_valid_b), .cmd_adr(cmd_adr_b),
    .cmd_data(cmd_data_b), .cmd_reply(cmd_reply_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitors: cumulative counts plus values captured during pulses.
  int n_req_a = 0, n_val_a = 0, n_err_a = 0, n_gate_a = 0;
  int n_req_b = 0, n_val_b = 0, n_err_b = 0, n_gate_b = 0;
  logic [2:0]  lra, lca;
  logic [7:0]  lda;
  logic        lrpa;
  logic [3:0]  lrb, lcb;
  logic [15:0] ldb;
  logic        lrpb;

  always @(negedge clk) begin
    if (reply_req_a) begin n_req_a++; lra = reply_adr_a; end
    if (cmd_valid_a) begin n_val_a++; lca = cmd_adr_a; lda = cmd_data_a; lrpa = cmd_reply_a; end
    else if (cmd_adr_a != 0 || cmd_data_a != 0 || cmd_reply_a) n_gate_a++;
    if (frame_err_a) n_err_a++;
    if (reply_req_b) begin n_req_b++; lrb = reply_adr_b; end
    if (cmd_valid_b) begin n_val_b++; lcb = cmd_adr_b; ldb = cmd_data_b; lrpb = cmd_reply_b; end
    else if (cmd_adr_b != 0 || cmd_data_b != 0 || cmd_reply_b) n_gate_b++;
    if (frame_err_b) n_err_b++;
  end

  // Responders drive a wrong word until 2 clk after reply_req, then the real one.
  initial begin
    rdata_a = '0;
    forever begin
      @(negedge clk);
      if (reply_req_a) begin
        rdata_a = ~resp_a;
        repeat (2) @(negedge clk);
        rdata_a = resp_a;
      end
    end
  end

  initial begin
    rdata_b = '0;
    forever begin
      @(negedge clk);
      if (reply_req_b) begin
        rdata_b = ~resp_b;
        repeat (2) @(negedge clk);
        rdata_b = resp_b;
      end
    end
  end

  int b_req, b_val, b_err;

  task automatic snap_a();
    b_req = n_req_a; b_val = n_val_a; b_err = n_err_a;
  endtask

  task automatic snap_b();
    b_req = n_req_b; b_val = n_val_b; b_err = n_err_b;
  endtask

  // Master: n edges, sdi = bits[n-1..0]; cap collects sdo seen just before each rising edge.
  task automatic run_frame(input bit which, input int n, input logic [63:0] bits,
                           input int rst_at, output logic [63:0] cap, output int err_before);
    cap = '0;
    if (which) sel_b = 1'b0; else sel_a = 1'b0;
    #100;
    for (int i = 1; i <= n; i++) begin
      cap = {cap[62:0], which ? sdo_b : sdo_a};
      sck = 1'b1;
      sdi = bits[n-i];
      #HALF;
      sck = 1'b0;
      #HALF;
      if (i == rst_at) begin
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    err_before = which ? n_err_b : n_err_a;
    #HALF;
    sdi = 1'b0;
    sel_a = 1'b1;
    sel_b = 1'b1;
    #200;
  endtask

  logic [63:0] cap;
  int eb;

  initial begin
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("reset_outs_a", {sdo_a, reply_req_a, cmd_valid_a, frame_err_a, busy_a,
                              cmd_adr_a, cmd_data_a, cmd_reply_a, reply_adr_a}, 0);
    check_eq("reset_outs_b", {sdo_b, reply_req_b, cmd_valid_b, frame_err_b, busy_b,
                              cmd_adr_b, cmd_data_b, cmd_reply_b, reply_adr_b}, 0);

    // Zero-edge select window: busy follows sel, nothing else happens.
    snap_a();
    sel_a = 1'b0; #100;
    check_eq("busy_high", busy_a, 1);
    sel_a = 1'b1; #100;
    check_eq("busy_low", busy_a, 0);
    check_eq("zero_edge_err", n_err_a - b_err, 0);

    // rq=1 adr=5 cmd=A5: header 1000, turn 0, reply 3C.
    snap_a();
    run_frame(0, 13, 64'h1AA5, 0, cap, eb);
    check_eq("t1_sdo", cap, 64'h103C);
    check_eq("t1_req", n_req_a - b_req, 1);
    check_eq("t1_radr", lra, 5);
    check_eq("t1_valid", n_val_a - b_val, 1);
    check_eq("t1_cmd", {lca, lda, lrpa}, {3'd5, 8'hA5, 1'b1});
    check_eq("t1_err", n_err_a - b_err, 0);

    // rq=0: reply suppressed, reply_req still pulses.
    snap_a();
    run_frame(0, 13, 64'h0AA5, 0, cap, eb);
    check_eq("t2_sdo", cap, 64'h1000);
    check_eq("t2_req", n_req_a - b_req, 1);
    check_eq("t2_cmd", {n_val_a - b_val, lca, lda, lrpa}, {32'd1, 3'd5, 8'hA5, 1'b0});

    // Short frame of 7 edges, then a normal frame adr=1 cmd=01.
    snap_a();
    run_frame(0, 7, 64'h5B, 0, cap, eb);
    check_eq("t3_err", n_err_a - b_err, 1);
    check_eq("t3_valid", n_val_a - b_val, 0);
    snap_a();
    run_frame(0, 13, 64'h0201, 0, cap, eb);
    check_eq("t3_next_cmd", {n_val_a - b_val, lca, lda, lrpa}, {32'd1, 3'd1, 8'h01, 1'b0});
    check_eq("t3_next_err", n_err_a - b_err, 0);

    // 15 edges: one cmd_valid, sdo 0 beyond frame, frame_err only at sel rise.
    snap_a();
    run_frame(0, 15, 64'h6A97, 0, cap, eb);
    check_eq("t4_sdo", cap, 64'h40F0);
    check_eq("t4_cmd", {n_val_a - b_val, lca, lda, lrpa}, {32'd1, 3'd5, 8'hA5, 1'b1});
    check_eq("t4_err_before", eb - b_err, 0);
    check_eq("t4_err_after", n_err_a - b_err, 1);

    // Reset after edge 5 discards the frame silently; the next frame is received.
    snap_a();
    run_frame(0, 13, 64'h1AA5, 5, cap, eb);
    check_eq("t5_sdo", cap, 64'h1000);
    check_eq("t5_valid", n_val_a - b_val, 0);
    check_eq("t5_err", n_err_a - b_err, 0);
    snap_a();
    run_frame(0, 13, 64'h1AA5, 0, cap, eb);
    check_eq("t5_next_sdo", cap, 64'h103C);
    check_eq("t5_next_cmd", {n_val_a - b_val, lca, lda, lrpa}, {32'd1, 3'd5, 8'hA5, 1'b1});
    check_eq("gate_a", n_gate_a, 0);

    // Wide instance: FRAME=22, rq=1 adr=9 cmd=BEEF, status 10110, reply ABC.
    snap_b();
    run_frame(1, 22, 64'h32BEEF, 0, cap, eb);
    check_eq("t6_sdo", cap, 64'h2CABC0);
    check_eq("t6_req", {n_req_b - b_req, lrb}, {32'd1, 4'd9});
    check_eq("t6_cmd", {n_val_b - b_val, lcb, ldb, lrpb}, {32'd1, 4'd9, 16'hBEEF, 1'b1});
    check_eq("t6_err", n_err_b - b_err, 0);
    check_eq("gate_b", n_gate_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_slave_sync.md
Name: spi_cmd_slave_sync

Overview:
Parametrised, clock-synchronous successor of the keyboard CPLD's SPI command slave. It oversamples SCK/SEL/SDI in the system clock domain and receives framed commands: a reply-request flag, an address and a command word. In the same frame it returns status bits and an optional reply word fetched by handshake. It sits between the host SPI link and the command decoder / reply multiplexer.

Parameters:
ADR_WIDTH, 3, command address (number) width
CMD_WIDTH, 8, command data width
REPLY_WIDTH, 8, reply width; legal range 1..CMD_WIDTH
STAT_WIDTH, 2, status bits (e.g. patient buttons) shifted out in header; legal range 1..ADR_WIDTH+1

Ports:
clk  in  1  system clock; must be at least 8x SCK frequency
rst  in  1  synchronous, active-high reset
sck  in  1  SPI clock, async; idle low
sel  in  1  chip select, async, active low
sdi  in  1  SPI data in, async
sdo  out  1  SPI data out, registered
status_in  in  STAT_WIDTH  status word, snapshotted at frame start
reply_req  out  1  one-clk pulse: reply word wanted for reply_adr
reply_adr  out  ADR_WIDTH  address of the pending reply, held until next frame
reply_data  in  REPLY_WIDTH  reply word, sampled at turnaround edge
cmd_valid  out  1  one-clk pulse: complete command received
cmd_adr  out  ADR_WIDTH  command address; zero except while cmd_valid=1
cmd_data  out  CMD_WIDTH  command data; zero except while cmd_valid=1
cmd_reply  out  1  frame's reply-request flag; zero except while cmd_valid=1
frame_err  out  1  one-clk pulse: frame ended short or over-long
busy  out  1  synchronized SEL active

Behaviour:
- sck, sel and sdi pass through 2-flop synchronizers. A falling edge of sck is detected from the synchronized samples (prev=1, cur=0). Every action is taken in the clk cycle after detection.
- Framing constants: H = 1+ADR_WIDTH and FRAME = H+1+CMD_WIDTH (13 with defaults). Falling edges are counted 1..FRAME per frame; the counter saturates at FRAME+1.
- Bit order is MSB first. The slave samples sdi and updates sdo on the falling edge. The master samples sdo on the rising edge.
- sdi layout by edge number:
  - edge 1: rq flag (1 = reply wanted)
  - edges 2..H: address
  - edge H+1: turnaround; sdi ignored
  - edges H+2..FRAME: command data
- sdo layout:
  - On synchronized sel falling, snapshot status_in and drive sdo = status[STAT_WIDTH-1].
  - After edge k, for k = 1..H-1, drive status[STAT_WIDTH-1-k], or 0 once the status bits are exhausted.
  - After edge H, drive 0.
  - After edges H+1..H+REPLY_WIDTH, drive the reply bits MSB first if rq=1, else 0.
  - After that, drive 0.
  - sdo=0 whenever idle.
- Reply handshake: at edge H, reply_req pulses for 1 clk and reply_adr = the received address. reply_data is latched at edge H+1; the responder must hold it valid from 2 clk after reply_req. With clk >= 8x sck this leaves at least 2 clk of margin.
- reply_req pulses even when rq=0 (responder may ignore it); in that case sdo stays 0.
- At edge FRAME, cmd_valid pulses for 1 clk with cmd_adr/cmd_data/cmd_reply. These outputs are gated to 0 outside the pulse.
- State machine:
  - IDLE -> HEADER on sel active.
  - HEADER -> TURN at edge H.
  - TURN -> CMD at edge H+1.
  - CMD -> DONE at edge FRAME.
  - DONE -> IDLE on sel inactive.
  - Any state except IDLE/WAIT -> IDLE on sel inactive.
- Short frame: sel goes inactive before edge FRAME (with at least 1 edge seen) -> frame_err pulse, no cmd_valid, partial data discarded.
  - sel active/inactive with zero edges is silent.
- Over-long frame: more than FRAME edges -> sdo stays 0, extra sdi ignored, frame_err pulses at sel inactive. The cmd_valid already issued stands.
- Reset: all outputs 0, counters cleared, state IDLE.
  - If synchronized sel is active when rst releases, go to WAIT: ignore edges, then go to IDLE on sel inactive with no frame_err.
  - Reset mid-frame therefore discards that frame entirely.
- Back-to-back frames: sel may be inactive for as little as 2 clk between frames. Snapshot and counter reset on each new sel active.

Test Plan:
- Defaults, status_in=2'b10, frame rq=1, adr=3'b101, cmd=8'hA5, responder returns 8'h3C -> reply_req with reply_adr=5; sdo header 1,0,0,0; then 0x3C MSB first; one cmd_valid with cmd_adr=5, cmd_data=A5, cmd_reply=1; no frame_err.
- Same frame with rq=0 -> sdo all 0 after header; cmd_valid with cmd_reply=0; reply_req still pulses.
- sel deasserted after 7 edges -> frame_err pulse, no cmd_valid, cmd_* stay 0; next full frame adr=1, cmd=8'h01 decodes correctly.
- 15 edges in one sel window -> cmd_valid once at edge 13, sdo 0 thereafter, frame_err at sel rise.
- rst pulsed at edge 5 while sel low -> outputs 0, rest of frame ignored, no cmd_valid/frame_err; next frame is received normally.
- Params ADR_WIDTH=4, CMD_WIDTH=16, REPLY_WIDTH=12, STAT_WIDTH=5, cmd=16'hBEEF, reply 12'hABC -> FRAME=22, correct capture and reply bits.
